mem_wb_stage: RTL and testbench

//  MEM/WB boundary of the 5-stage RISC-V pipeline, directly downstream of the data-memory interface stage.

---
 rtl/mem_wb_stage_if.sv | 31 +++
 rtl/mem_wb_stage.sv | 155 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bundle: MEM-stage control/data inputs, DM response, and
// the registered writeback / status outputs of the stage.
interface mem_wb_stage_if;
   logic        flush;
   logic        MemRead;
   logic        RegWrite;
   logic        MemtoReg;
   logic [2:0]  funct3;
   logic [31:0] alu_out;
   logic [4:0]  rd;
   logic [31:0] data_out;
   logic        data_ready;
   logic        mem_stall;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_RegWrite;
   logic        load_misalign;
   logic        mem_err;

   modport master (
      output flush, MemRead, RegWrite, MemtoReg, funct3, alu_out, rd,
             data_out, data_ready,
      input  mem_stall, wb_data, wb_rd, wb_RegWrite, load_misalign, mem_err
   );

   modport slave (
      input  flush, MemRead, RegWrite, MemtoReg, funct3, alu_out, rd,
             data_out, data_ready,
      output mem_stall, wb_data, wb_rd, wb_RegWrite, load_misalign, mem_err
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: waits for DM load data (with timeout), aligns and
// extends loads, and registers the writeback result, destination and enable.
module mem_wb_stage #(
   parameter int unsigned MAX_WAIT = 15
) (
   input logic           clk,
   input logic           rst,
   mem_wb_stage_if.slave bus
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic        wb_RegWrite_q, wb_RegWrite_d;
   logic        load_misalign_q, load_misalign_d;
   logic        mem_err_q, mem_err_d;

   logic [1:0]  off;
   logic [7:0]  byte_lane [4];
   logic [15:0] half_lane [2];
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ext;
   logic        misaligned;
   logic        load_misaligned;
   logic        need_data;
   logic        at_limit;
   logic        stall;
   logic        timeout;
   logic        retire;

   assign off = bus.alu_out[1:0];

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = bus.data_out[8*gi +: 8];
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_lane[gi] = bus.data_out[16*gi +: 16];
   end

   always_comb begin
      ld_byte    = byte_lane[off];
      ld_half    = half_lane[off[1]];
      ext        = bus.data_out;
      misaligned = (off != 2'b00);
      // Unused encodings 011/110/111 fall through to the word case
      case (bus.funct3)
         3'b000: begin
            ext        = {{24{ld_byte[7]}}, ld_byte};
            misaligned = 1'b0;
         end
         3'b100: begin
            ext        = {24'h000000, ld_byte};
            misaligned = 1'b0;
         end
         3'b001: begin
            ext        = {{16{ld_half[15]}}, ld_half};
            misaligned = off[0];
         end
         3'b101: begin
            ext        = {16'h0000, ld_half};
            misaligned = off[0];
         end
         default: begin
            ext        = bus.data_out;
            misaligned = (off != 2'b00);
         end
      endcase
   end

   // A misaligned load is dropped at once, so it never waits on DM
   assign load_misaligned = bus.MemRead & misaligned;
   assign need_data       = bus.MemRead & ~misaligned & ~bus.data_ready & ~bus.flush;
   assign at_limit        = (state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST);
   assign stall           = need_data & ~at_limit;
   assign timeout         = need_data & at_limit;
   assign retire          = ~bus.flush & ~stall & ~timeout;

   // Flush forces stall low, so leaving WAIT on !stall also covers a squash
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (stall) begin
               state_d    = S_WAIT;
               wait_cnt_d = 8'd0;
            end
         end
         S_WAIT: begin
            if (stall) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end else begin
               state_d    = S_IDLE;
               wait_cnt_d = 8'd0;
            end
         end
         default: begin
            state_d    = S_IDLE;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   always_comb begin
      wb_data_d       = wb_data_q;
      wb_rd_d         = wb_rd_q;
      wb_RegWrite_d   = 1'b0;
      load_misalign_d = 1'b0;
      mem_err_d       = mem_err_q | timeout;
      if (retire) begin
         wb_rd_d         = bus.rd;
         wb_data_d       = bus.MemtoReg ? ext : bus.alu_out;
         wb_RegWrite_d   = bus.RegWrite & ~load_misaligned;
         load_misalign_d = load_misaligned;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         wait_cnt_q      <= 8'd0;
         wb_data_q       <= 32'h0000_0000;
         wb_rd_q         <= 5'd0;
         wb_RegWrite_q   <= 1'b0;
         load_misalign_q <= 1'b0;
         mem_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         wait_cnt_q      <= wait_cnt_d;
         wb_data_q       <= wb_data_d;
         wb_rd_q         <= wb_rd_d;
         wb_RegWrite_q   <= wb_RegWrite_d;
         load_misalign_q <= load_misalign_d;
         mem_err_q       <= mem_err_d;
      end
   end

   assign bus.mem_stall     = stall;
   assign bus.wb_data       = wb_data_q;
   assign bus.wb_rd         = wb_rd_q;
   assign bus.wb_RegWrite   = wb_RegWrite_q;
   assign bus.load_misalign = load_misalign_q;
   assign bus.mem_err       = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Random + directed bench for mem_wb_stage: a behavioural model queues the
// expected stall and writeback state per cycle; a monitor pops and compares.
module tb_mem_wb_stage;

   localparam int MAX_WAIT = 15;

   typedef struct {
      bit          stall;
      logic [31:0] data;
      logic [4:0]  rd;
      bit          we;
      bit          mis;
      bit          err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   mem_wb_stage_if bus();

   mem_wb_stage #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_cycles = 0;

   // stimulus variables
   bit          t_rst, t_flush, t_mr, t_rw, t_m2r, t_dr;
   logic [2:0]  t_f3;
   logic [31:0] t_alu, t_dout;
   logic [4:0]  t_rd;

   // model state
   logic [31:0] m_data = '0;
   logic [4:0]  m_rd   = '0;
   bit          m_we   = 0;
   bit          m_mis  = 0;
   bit          m_err  = 0;
   int          m_k    = 0;   // consecutive cycles the current load has stalled
   bit          last_stall = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int access_size(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] word);
      logic [31:0] b, h;
      b = (word >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
      h = (word >> (addr[1] ? 16 : 0)) & 32'h0000_FFFF;
      case (f3)
         3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'b100:  return b;
         3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
         3'b101:  return h;
         default: return word;
      endcase
   endfunction

   task automatic idle_instr();
      t_rst = 0; t_flush = 0; t_mr = 0; t_rw = 0; t_m2r = 0; t_dr = 0;
      t_f3 = 3'b010; t_alu = '0; t_dout = '0; t_rd = '0;
   endtask

   task automatic step();
      exp_t e;
      int   sz;
      bit   mis, need, stl, tmo;
      rst            = t_rst;
      bus.flush      = t_flush;
      bus.MemRead    = t_mr;
      bus.RegWrite   = t_rw;
      bus.MemtoReg   = t_m2r;
      bus.funct3     = t_f3;
      bus.alu_out    = t_alu;
      bus.rd         = t_rd;
      bus.data_out   = t_dout;
      bus.data_ready = t_dr;
      sz   = access_size(t_f3);
      mis  = t_mr && ((int'(t_alu[1:0]) % sz) != 0);
      need = t_mr && !mis && !t_dr && !t_flush;
      stl  = need && (m_k < MAX_WAIT);
      tmo  = need && (m_k >= MAX_WAIT);
      if (t_rst) begin
         m_data = '0; m_rd = '0; m_we = 0; m_mis = 0; m_err = 0; m_k = 0;
      end else if (t_flush) begin
         m_we = 0; m_mis = 0; m_k = 0;
      end else if (stl) begin
         m_we = 0; m_mis = 0; m_k++;
      end else if (tmo) begin
         m_we = 0; m_mis = 0; m_err = 1; m_k = 0;
      end else begin
         m_rd   = t_rd;
         m_data = t_m2r ? model_load(t_f3, t_alu, t_dout) : t_alu;
         m_we   = t_rw && !mis;
         m_mis  = mis;
         m_k    = 0;
      end
      e.stall = stl; e.data = m_data; e.rd = m_rd; e.we = m_we; e.mis = m_mis; e.err = m_err;
      exp_q.push_back(e);
      last_stall = stl;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word,
                       input bit ready, input logic [4:0] dst);
      idle_instr();
      t_mr = 1; t_rw = 1; t_m2r = 1; t_f3 = f3; t_alu = addr; t_dout = word;
      t_dr = ready; t_rd = dst;
   endtask

   // monitor: stall is checked mid-cycle, registered outputs after the edge
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("mem_stall", 32'(bus.mem_stall), 32'(e.stall));
            @(posedge clk);
            #2;
            chk("wb_data", bus.wb_data, e.data);
            chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
            chk("wb_RegWrite", 32'(bus.wb_RegWrite), 32'(e.we));
            chk("load_misalign", 32'(bus.load_misalign), 32'(e.mis));
            chk("mem_err", 32'(bus.mem_err), 32'(e.err));
            $display("cyc %0d stall=%0b we=%0b rd=%0d data=%08h mis=%0b err=%0b",
                     n_cycles, e.stall, bus.wb_RegWrite, bus.wb_rd, bus.wb_data,
                     bus.load_misalign, bus.mem_err);
            n_cycles++;
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin : stimulus
      int  lat;
      int  r;
      bit  held;
      idle_instr();
      rst = 1'b1;
      bus.flush = 0; bus.MemRead = 0; bus.RegWrite = 0; bus.MemtoReg = 0;
      bus.funct3 = '0; bus.alu_out = '0; bus.rd = '0; bus.data_out = '0; bus.data_ready = 0;
      @(posedge clk);
      #1;

      // reset
      t_rst = 1; step(); step();
      chk("rst_wb_data", bus.wb_data, 32'h0);
      chk("rst_wb_RegWrite", 32'(bus.wb_RegWrite), 32'h0);

      // LB sign extension, zero latency
      load(3'b000, 32'h0000_0103, 32'h8000_0000, 1, 5'd5); step();
      chk("lb_data", bus.wb_data, 32'hFFFF_FF80);
      chk("lb_we", 32'(bus.wb_RegWrite), 32'h1);

      load(3'b101, 32'h0000_0042, 32'hBEEF_1234, 1, 5'd6); step();
      chk("lhu_data", bus.wb_data, 32'h0000_BEEF);
      load(3'b001, 32'h0000_0042, 32'hBEEF_1234, 1, 5'd7); step();
      chk("lh_data", bus.wb_data, 32'hFFFF_BEEF);

      // LW with three cycles of DM latency
      for (int i = 0; i < 3; i++) begin
         load(3'b010, 32'h0000_0080, 32'h1357_9BDF, 0, 5'd8); step();
         chk("lw_wait_bubble", 32'(bus.wb_RegWrite), 32'h0);
      end
      load(3'b010, 32'h0000_0080, 32'h1357_9BDF, 1, 5'd8); step();
      chk("lw_wait_data", bus.wb_data, 32'h1357_9BDF);

      // misaligned LW
      load(3'b010, 32'h0000_0082, 32'hAAAA_AAAA, 0, 5'd9); step();
      chk("mis_pulse", 32'(bus.load_misalign), 32'h1);
      chk("mis_we", 32'(bus.wb_RegWrite), 32'h0);
      idle_instr(); step();
      chk("mis_pulse_end", 32'(bus.load_misalign), 32'h0);

      // DM never answers -> timeout after MAX_WAIT stalled cycles
      for (int i = 0; i < MAX_WAIT; i++) begin
         load(3'b010, 32'h0000_0100, 32'h0, 0, 5'd10); step();
      end
      chk("pre_timeout_err", 32'(bus.mem_err), 32'h0);
      load(3'b010, 32'h0000_0100, 32'h0, 0, 5'd10); step();
      chk("timeout_err", 32'(bus.mem_err), 32'h1);
      chk("timeout_we", 32'(bus.wb_RegWrite), 32'h0);

      // flush during WAIT
      load(3'b010, 32'h0000_0200, 32'h0, 0, 5'd11); step(); step();
      t_flush = 1; step();
      chk("flush_we", 32'(bus.wb_RegWrite), 32'h0);
      chk("flush_err_kept", 32'(bus.mem_err), 32'h1);

      // reset during WAIT
      load(3'b010, 32'h0000_0300, 32'h0, 0, 5'd12); step(); step();
      t_rst = 1; step();
      chk("rst_wait_err", 32'(bus.mem_err), 32'h0);
      chk("rst_wait_rd", 32'(bus.wb_rd), 32'h0);

      // randomized traffic; the MEM instruction is held while stalled
      held = 0;
      lat  = 0;
      for (int c = 0; c < 3000; c++) begin
         t_rst   = ($urandom_range(0, 199) == 0);
         t_flush = ($urandom_range(0, 19) == 0);
         if (!held) begin
            t_mr  = ($urandom_range(0, 9) < 6);
            t_f3  = 3'($urandom);
            t_alu = $urandom;
            if ($urandom_range(0, 1) == 0) t_alu[1:0] = 2'b00;
            t_rd  = 5'($urandom);
            t_rw  = ($urandom_range(0, 7) != 0);
            t_m2r = t_mr ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            r     = $urandom_range(0, 9);
            lat   = (r < 5) ? 0 : (r < 9) ? $urandom_range(1, 6) : 1000;
         end
         t_dout = $urandom;
         t_dr   = t_mr ? (lat == 0) : bit'($urandom_range(0, 1));
         step();
         held = last_stall;
         if (held && lat > 0) lat--;
      end

      idle_instr();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
